// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-256 key-schedule controller: one shared key-step unit, sequenced r=1..7,
// 15 x 128-bit round-key store with a registered read port. Optional timeout: AES_KEY_SCHED_TIMEOUT_EN.
module aes_key_sched_ctrl #(
  parameter int NUM_ROUND_KEYS = 15,
  parameter int NUM_STEPS      = 7
`ifdef AES_KEY_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           key_v_i,
  input  logic [0:255]   key_i,
  output logic           key_ready_o,
  output logic           step_v_o,
  output logic [0:255]   step_k_o,
  output logic [3:0]     step_r_o,
  input  logic           step_ready_i,
  input  logic           step_v_i,
  input  logic [0:255]   step_k_i,
  input  logic           rk_rd_v_i,
  input  logic [3:0]     rk_addr_i,
  output logic [0:127]   rk_data_o,
  output logic           rk_data_v_o,
  output logic           keys_valid_o,
  output logic           busy_o,
  output logic           err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [3:0]   r;
  logic [3:0]   count;
  logic [0:255] cur_k;
  logic [0:127] rk [0:NUM_ROUND_KEYS-1];

  logic accept;
  logic step_done;
  logic last_step;
  logic timeout;

  assign accept    = key_v_i && ((state == IDLE) || (state == DONE));
  assign step_done = (state == WAIT) && step_v_i;
  assign last_step = (r == 4'(NUM_STEPS));

  // The step request is driven straight from the key-material and round registers.
  assign step_k_o = cur_k;
  assign step_r_o = r;

`ifdef AES_KEY_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err;

  assign timeout = (state == WAIT) && !step_v_i && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_o   = err;

  // Wait-cycle counter: held at zero in REQ so every WAIT visit starts fresh.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt <= {TW{1'b0}};
    end else if (state == REQ) begin
      tmo_cnt <= {TW{1'b0}};
    end else if ((state == WAIT) && !step_v_i) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end

  // Sticky timeout flag, cleared only by the next accepted key.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Next-state decode for the expansion sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (key_v_i) begin
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (step_ready_i) begin
          state_next = WAIT;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (step_v_i) begin
          state_next = last_step ? DONE : REQ;
        end else if (timeout) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      DONE: begin
        if (key_v_i) begin
          state_next = REQ;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sequencer state, handshake outputs and round-key storage.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      r            <= 4'd0;
      count        <= 4'd0;
      cur_k        <= 256'h0;
      key_ready_o  <= 1'b1;
      step_v_o     <= 1'b0;
      busy_o       <= 1'b0;
      keys_valid_o <= 1'b0;
      for (int i = 0; i < NUM_ROUND_KEYS; i++) begin
        rk[i] <= 128'h0;
      end
    end else begin
      state       <= state_next;
      key_ready_o <= (state_next == IDLE) || (state_next == DONE);
      step_v_o    <= (state_next == REQ);
      busy_o      <= (state_next == REQ) || (state_next == WAIT);
      if (accept) begin
        rk[0]        <= key_i[0:127];
        rk[1]        <= key_i[128:255];
        cur_k        <= key_i;
        count        <= 4'd2;
        r            <= 4'd1;
        keys_valid_o <= 1'b0;
      end else if (step_done) begin
        cur_k                 <= step_k_i;
        rk[{r[2:0], 1'b0}]    <= step_k_i[0:127];
        if (last_step) begin
          // Final step contributes only the upper half (round key 14).
          count        <= 4'(NUM_ROUND_KEYS);
          keys_valid_o <= 1'b1;
        end else begin
          rk[{r[2:0], 1'b1}] <= step_k_i[128:255];
          count              <= count + 4'd2;
          r                  <= r + 4'd1;
        end
      end
    end
  end

  // Registered read port; validity uses the pre-update count, so a same-edge write reads invalid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rk_data_o   <= 128'h0;
      rk_data_v_o <= 1'b0;
    end else if (rk_rd_v_i) begin
      if (rk_addr_i < 4'(NUM_ROUND_KEYS)) begin
        rk_data_o   <= rk[rk_addr_i];
        rk_data_v_o <= (rk_addr_i < count);
      end else begin
        rk_data_o   <= 128'h0;
        rk_data_v_o <= 1'b0;
      end
    end else begin
      rk_data_v_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a FIPS-197 AES-256 key-step model.
// Timeout checks run only when AES_KEY_SCHED_TIMEOUT_EN is defined.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         key_v_i;
  logic [0:255] key_i;
  logic         key_ready_o;
  logic         step_v_o;
  logic [0:255] step_k_o;
  logic [3:0]   step_r_o;
  logic         step_ready_i = 1'b0;
  logic         step_v_i = 1'b0;
  logic [0:255] step_k_i = 256'h0;
  logic         rk_rd_v_i;
  logic [3:0]   rk_addr_i;
  logic [0:127] rk_data_o;
  logic         rk_data_v_o;
  logic         keys_valid_o;
  logic         busy_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  logic [0:127] exp_rk  [0:14];
  logic [0:255] exp_mat [0:7];

  // step-unit model controls
  int           stall_cfg = 0;
  int           stall_cnt = 0;
  int           withhold_r = 0;
  bit           release_held = 1'b0;
  bit           model_en = 1'b1;
  bit           pending = 1'b0;
  bit           held = 1'b0;
  logic [0:255] pend_k;
  logic [0:255] held_k;

  localparam logic [0:255] KEY0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:255] KEYF = {256{1'b1}};

  aes_key_sched_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .key_v_i      (key_v_i),
    .key_i        (key_i),
    .key_ready_o  (key_ready_o),
    .step_v_o     (step_v_o),
    .step_k_o     (step_k_o),
    .step_r_o     (step_r_o),
    .step_ready_i (step_ready_i),
    .step_v_i     (step_v_i),
    .step_k_i     (step_k_i),
    .rk_rd_v_i    (rk_rd_v_i),
    .rk_addr_i    (rk_addr_i),
    .rk_data_o    (rk_data_o),
    .rk_data_v_o  (rk_data_v_o),
    .keys_valid_o (keys_valid_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h01;
    if (x == 8'h00) y = 8'h00;
    else repeat (254) y = gmul(y, x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One AES-256 key-step: 8 previous words in, 8 next words out.
  function automatic logic [0:255] step_fn(input logic [0:255] k, input int r);
    logic [31:0]  w [0:15];
    logic [31:0]  rcon;
    logic [7:0]   rc;
    logic [0:255] o;
    for (int j = 0; j < 8; j++) w[j] = k[32*j +: 32];
    rc = 8'h01 << (r - 1);
    rcon = {rc, 24'h000000};
    w[8] = w[0] ^ subword({w[7][23:0], w[7][31:24]}) ^ rcon;
    for (int j = 9; j < 16; j++) begin
      if (j == 12) w[j] = w[j-8] ^ subword(w[j-1]);
      else w[j] = w[j-8] ^ w[j-1];
    end
    for (int j = 0; j < 8; j++) o[32*j +: 32] = w[8+j];
    return o;
  endfunction

  task automatic build_exp(input logic [0:255] key);
    logic [0:255] mat;
    mat = key;
    exp_mat[0] = key;
    exp_rk[0] = key[0:127];
    exp_rk[1] = key[128:255];
    for (int r = 1; r <= 7; r++) begin
      mat = step_fn(mat, r);
      exp_mat[r] = mat;
      exp_rk[2*r] = mat[0:127];
      if (r < 7) exp_rk[2*r+1] = mat[128:255];
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic ev, input logic [0:127] ed);
    rk_rd_v_i = 1'b1;
    rk_addr_i = a;
    @(negedge clk);
    rk_rd_v_i = 1'b0;
    chk({tag, "_v"}, 256'(rk_data_v_o), 256'(ev));
    chk({tag, "_d"}, 256'(rk_data_o), 256'(ed));
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 15; a++) rd($sformatf("%s_rk%0d", tag, a), 4'(a), 1'b1, exp_rk[a]);
    rd({tag, "_rk15"}, 4'd15, 1'b0, 128'h0);
  endtask

  task automatic wait_valid(input string tag, input int start_n, input int exp_n);
    int n;
    n = start_n;
    while (!keys_valid_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 256'(n), 256'(exp_n));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 256'(key_ready_o), 256'(1'b1));
    chk({tag, "_stepv"}, 256'(step_v_o), 256'(1'b0));
    chk({tag, "_stepk"}, 256'(step_k_o), 256'h0);
    chk({tag, "_stepr"}, 256'(step_r_o), 256'h0);
    chk({tag, "_busy"}, 256'(busy_o), 256'(1'b0));
    chk({tag, "_kvalid"}, 256'(keys_valid_o), 256'(1'b0));
    chk({tag, "_rdv"}, 256'(rk_data_v_o), 256'(1'b0));
    chk({tag, "_rdd"}, 256'(rk_data_o), 256'h0);
    chk({tag, "_err"}, 256'(err_o), 256'(1'b0));
  endtask

  // Step-unit model: grants after stall_cfg cycles, answers one cycle after the grant.
  always @(negedge clk) begin
    step_v_i = 1'b0;
    if (!model_en) begin
      held = 1'b0;
      pending = 1'b0;
      step_ready_i = 1'b0;
      stall_cnt = 0;
    end else begin
      if (pending) begin
        step_v_i = 1'b1;
        step_k_i = pend_k;
        pending = 1'b0;
      end else if (held && release_held) begin
        step_v_i = 1'b1;
        step_k_i = held_k;
        held = 1'b0;
      end
      if (step_v_o) begin
        if (stall_cnt < stall_cfg) begin
          step_ready_i = 1'b0;
          stall_cnt++;
        end else begin
          step_ready_i = 1'b1;
          stall_cnt = 0;
          if (int'(step_r_o) == withhold_r) begin
            held = 1'b1;
            held_k = step_fn(step_k_o, int'(step_r_o));
          end else begin
            pending = 1'b1;
            pend_k = step_fn(step_k_o, int'(step_r_o));
          end
        end
      end else begin
        step_ready_i = 1'b0;
      end
    end
  end

  initial begin
    int n;
    bit found;
    bit prev_v;
    logic [3:0] prev_r;
    logic [0:127] old_rk2;

    reset_i = 1'b1;
    key_v_i = 1'b0;
    key_i = 256'h0;
    rk_rd_v_i = 1'b0;
    rk_addr_i = 4'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset_i = 1'b0;
    @(negedge clk);

    // model anchored to FIPS-197 AES-256 schedule
    build_exp(KEY0);
    chk("fips_rk2", 256'(exp_rk[2]), 256'(128'ha573c29fa176c498a97fce93a572c09c));
    chk("fips_rk14", 256'(exp_rk[14]), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));

    // nominal expansion with partial reads mid-run
    key_i = KEY0;
    key_v_i = 1'b1;
    @(negedge clk);
    key_v_i = 1'b0;
    chk("acc_ready", 256'(key_ready_o), 256'(1'b0));
    chk("acc_busy", 256'(busy_o), 256'(1'b1));
    chk("acc_stepv", 256'(step_v_o), 256'(1'b1));
    chk("acc_stepr", 256'(step_r_o), 256'(4'd1));
    chk("acc_stepk", 256'(step_k_o), 256'(KEY0));
    repeat (4) @(negedge clk);
    rk_rd_v_i = 1'b1;
    rk_addr_i = 4'd4;
    @(negedge clk);
    chk("part_rd4_v", 256'(rk_data_v_o), 256'(1'b1));
    chk("part_rd4_d", 256'(rk_data_o), 256'(exp_rk[4]));
    rk_addr_i = 4'd6;
    @(negedge clk);
    rk_rd_v_i = 1'b0;
    chk("part_rd6_v", 256'(rk_data_v_o), 256'(1'b0));
    wait_valid("nom", 6, 14);
    chk("nom_ready", 256'(key_ready_o), 256'(1'b1));
    chk("nom_busy", 256'(busy_o), 256'(1'b0));
    chk("nom_err", 256'(err_o), 256'(1'b0));
    read_all("nom");
    rd("hold_pre", 4'd3, 1'b1, exp_rk[3]);
    @(negedge clk);
    chk("hold_v", 256'(rk_data_v_o), 256'(1'b0));
    chk("hold_d", 256'(rk_data_o), 256'(exp_rk[3]));

    // rekey from DONE with all-ones key
    old_rk2 = exp_rk[2];
    build_exp(KEYF);
    key_i = KEYF;
    key_v_i = 1'b1;
    @(negedge clk);
    key_v_i = 1'b0;
    chk("rekey_kvalid", 256'(keys_valid_o), 256'(1'b0));
    rd("rekey_rd2", 4'd2, 1'b0, old_rk2);
    rd("rekey_rd0", 4'd0, 1'b1, 128'hffffffffffffffffffffffffffffffff);
    wait_valid("rekey", 2, 14);
    read_all("rekey");

    // backpressure: three stall cycles per request
    build_exp(KEY0);
    stall_cfg = 3;
    key_i = KEY0;
    key_v_i = 1'b1;
    @(negedge clk);
    key_v_i = 1'b0;
    n = 0;
    prev_v = 1'b0;
    prev_r = 4'd0;
    while (!keys_valid_o && n < 400) begin
      if (step_v_o) begin
        chk("bp_stepk", 256'(step_k_o), 256'(exp_mat[int'(step_r_o) - 1]));
        if (prev_v) chk("bp_stepr_stable", 256'(step_r_o), 256'(prev_r));
      end
      prev_v = step_v_o;
      prev_r = step_r_o;
      @(negedge clk);
      n++;
    end
    chk("bp_lat", 256'(n), 256'(35));
    rd("bp_rk14", 4'd14, 1'b1, exp_rk[14]);
    rd("bp_rk9", 4'd9, 1'b1, exp_rk[9]);
    stall_cfg = 0;

    // reset during the r=4 wait, then a stray step response
    withhold_r = 4;
    key_i = KEY0;
    key_v_i = 1'b1;
    @(negedge clk);
    key_v_i = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      if (busy_o && !step_v_o && step_r_o == 4'd4) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("mid_found_wait4", 256'(found), 256'(1'b1));
    reset_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    reset_i = 1'b0;
    release_held = 1'b1;
    repeat (3) @(negedge clk);
    release_held = 1'b0;
    withhold_r = 0;
    check_reset_outputs("mid_post");
    rd("mid_rd8", 4'd8, 1'b0, 128'h0);
    rd("mid_rd0", 4'd0, 1'b0, 128'h0);

`ifdef AES_KEY_SCHED_TIMEOUT_EN
    // withhold the r=3 response until the controller gives up
    withhold_r = 3;
    key_i = KEY0;
    key_v_i = 1'b1;
    @(negedge clk);
    key_v_i = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      if (busy_o && !step_v_o && step_r_o == 4'd3) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("tmo_found_wait3", 256'(found), 256'(1'b1));
    n = 0;
    while (!err_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_lat", 256'(n), 256'(64));
    chk("tmo_ready", 256'(key_ready_o), 256'(1'b1));
    chk("tmo_busy", 256'(busy_o), 256'(1'b0));
    chk("tmo_kvalid", 256'(keys_valid_o), 256'(1'b0));
    rd("tmo_rd5", 4'd5, 1'b1, exp_rk[5]);
    rd("tmo_rd6", 4'd6, 1'b0, 128'h0);
    model_en = 1'b0;
    repeat (2) @(negedge clk);
    model_en = 1'b1;
    withhold_r = 0;
    key_i = KEY0;
    key_v_i = 1'b1;
    @(negedge clk);
    key_v_i = 1'b0;
    chk("tmo_err_clear", 256'(err_o), 256'(1'b0));
    wait_valid("tmo_after", 0, 14);
`else
    chk("err_tied", 256'(err_o), 256'(1'b0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Iterative controller for the AES-256 key schedule.
- Accepts a 256-bit cipher key, then drives one shared key-step unit (round_key-style: takes previous 256-bit key material and round index r, returns next 256 bits) seven times, r=1..7.
- Stores the resulting 15 x 128-bit round keys in an internal register file and serves them to the encryption datapath through a registered read port.
- Replaces the fully unrolled 7-stage expansion chain with one step unit plus sequencing.

Parameters:
- NUM_ROUND_KEYS, 15, number of 128-bit round keys stored (AES-256).
- NUM_STEPS, 7, key-step invocations per expansion.
- TIMEOUT_CYCLES, 64, max cycles waited for a step response (used only with the optional feature).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- key_v_i  input  1  new cipher key valid.
- key_i  input  [0:255]  cipher key; bit 0 is MSB.
- key_ready_o  output  1  controller can accept a key.
- step_v_o  output  1  request valid to key-step unit.
- step_k_o  output  [0:255]  previous key material sent to step unit.
- step_r_o  output  4  round index r, 1..7.
- step_ready_i  input  1  step unit accepts request.
- step_v_i  input  1  step result valid.
- step_k_i  input  [0:255]  step result.
- rk_rd_v_i  input  1  round-key read request.
- rk_addr_i  input  4  round-key index, 0..15.
- rk_data_o  output  [0:127]  registered round key.
- rk_data_v_o  output  1  rk_data_o holds a valid key.
- keys_valid_o  output  1  all 15 round keys present.
- busy_o  output  1  expansion in progress.
- err_o  output  1  step timeout flag.

Behaviour:
- Reset (async, reset_i=1): state=IDLE, r=0, count=0, cur_k=0, all storage=0. All outputs 0 except key_ready_o=1.
- States: IDLE, REQ, WAIT, DONE.
- key_ready_o=1 in IDLE and DONE. A key is accepted on an edge where key_v_i & key_ready_o.
- Accept:
  - rk[0]<=key_i[0:127], rk[1]<=key_i[128:255].
  - cur_k<=key_i, count<=2, r<=1, err_o<=0, keys_valid_o<=0, state->REQ.
- REQ:
  - step_v_o=1, step_k_o=cur_k, step_r_o=r; both outputs stable while waiting.
  - step_v_o & step_ready_i -> WAIT.
- WAIT: on step_v_i:
  - cur_k<=step_k_i.
  - rk[2r]<=step_k_i[0:127].
  - If r<7: rk[2r+1]<=step_k_i[128:255], count<=count+2, r<=r+1, state->REQ.
  - If r==7: store only rk[14], count<=15, state->DONE, keys_valid_o<=1.
- busy_o=1 in REQ and WAIT.
- step_v_i outside WAIT is ignored. step_ready_i outside REQ is ignored.
- Latency: with step_ready_i=1 and the response one cycle after the request, each round takes 2 cycles. keys_valid_o rises 14 edges after the accept edge.
- Rekey in DONE: accepted immediately; keys_valid_o clears on the accept edge and old rk[2..14] become invalid (count=2).
- Key offered in REQ/WAIT: not accepted (key_ready_o=0); the requester holds it.
- Read port, registered, 1-cycle latency:
  - On edge with rk_rd_v_i: rk_data_o<=rk[addr], rk_data_v_o<=(addr<count).
  - Count is sampled pre-update, so a same-edge write to addr yields v=0.
  - addr>=15: rk_data_o<=0, v=0.
  - No rk_rd_v_i: rk_data_v_o<=0, rk_data_o holds.
- Reset mid-expansion: immediate return to reset state; any in-flight step response after reset is ignored (state IDLE).

Optional Feature:
- Macro: AES_KEY_SCHED_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES with no step_v_i: state->IDLE, err_o<=1 (sticky until next accepted key), busy_o=0.
  - keys_valid_o stays 0; keys already stored remain readable per count.
- Not defined: WAIT lasts indefinitely, no counter logic, err_o tied 0.

Test Plan:
- Nominal: key_i=0x000102...1F, step model = FIPS-197 AES-256 expansion, 1-cycle response -> keys_valid_o high 14 edges after accept; rk[0]=000102..0F, rk[14]=24fc79cc bf0979e9 371ac23c 6d68de36 (FIPS-197 A.3).
- Backpressure: step_ready_i low 3 cycles per request -> step_k_o/step_r_o stable during stall, keys_valid_o at edge 35, same keys.
- Partial read: read addr 4 after 2nd response, addr 6 before 3rd -> rk_data_v_o=1 with correct rk[4], then rk_data_v_o=0; addr 15 -> v=0, data 0.
- Rekey: new key (all 0xFF) in DONE -> keys_valid_o drops next edge, read addr 2 gives v=0, new rk[0]=FF..FF, new set complete after 14 more edges.
- Reset mid-run: assert reset_i during r=4 WAIT, then a stray step_v_i -> outputs at reset values, key_ready_o=1, no storage write.
- Timeout (AES_KEY_SCHED_TIMEOUT_EN): withhold step_v_i at r=3 -> after 64 WAIT cycles err_o=1, state IDLE, rk[5] readable v=1, rk[6] v=0; next accept clears err_o.
